// File: rtl/alu_muldiv_seq_if.sv
// rtl/alu_muldiv_seq_if.sv - start/operand/result and external ALU signal bundle for alu_muldiv_seq
interface alu_muldiv_seq_if;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [31:0] alu_result;
    logic        alu_overflow;
    logic [31:0] alu_opA;
    logic [31:0] alu_opB;
    logic [4:0]  alu_opcode;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    modport master (
        output ctrl_MULT, ctrl_DIV, data_operandA, data_operandB, alu_result, alu_overflow,
        input  alu_opA, alu_opB, alu_opcode, data_result, data_exception, data_resultRDY, busy
    );

    modport slave (
        input  ctrl_MULT, ctrl_DIV, data_operandA, data_operandB, alu_result, alu_overflow,
        output alu_opA, alu_opB, alu_opcode, data_result, data_exception, data_resultRDY, busy
    );
endinterface

// File: rtl/alu_muldiv_seq.sv
// rtl/alu_muldiv_seq.sv - Booth multiply / restoring divide sequencer driving an external 32-bit ALU (option: MULDIV_EARLY_ZERO_EN)
module alu_muldiv_seq (
    input logic         clock,
    input logic         reset,
    alu_muldiv_seq_if.slave bus
);

`ifdef MULDIV_EARLY_ZERO_EN
    localparam logic early_zero_en = 1'b1;
`else
    localparam logic early_zero_en = 1'b0;
`endif

    localparam logic [4:0] op_add = 5'b00000;
    localparam logic [4:0] op_sub = 5'b00001;

    typedef enum logic [2:0] {
        IDLE, MUL_IT, DIV_NA, DIV_NB, DIV_IT, DIV_FIX, DONE
    } state_t;

    state_t      state, state_nxt;
    // p_reg: Booth high word / divide remainder; q_reg: Booth low word / quotient
    // (also parks |A| during the divide prologue); m_reg: multiplicand / |divisor|
    logic [31:0] p_reg, p_nxt;
    logic [31:0] q_reg, q_nxt;
    logic [31:0] m_reg, m_nxt;
    logic        qm1_reg, qm1_nxt;
    logic [5:0]  cnt, cnt_nxt;
    logic        is_mul, is_mul_nxt;
    logic        sign_diff, sign_diff_nxt;
    logic        div_zero, div_zero_nxt;
    logic [31:0] result_reg;
    logic        exception_reg;

    logic [31:0] alu_a, alu_b;
    logic [4:0]  alu_op;
    logic        shift_sign;
    logic        borrow;
    logic [31:0] r_sh;
    logic        done_exc;

    // Next-state, datapath updates and ALU drive; a start pulse overrides whatever is in flight
    always_comb begin
        state_nxt     = state;
        p_nxt         = p_reg;
        q_nxt         = q_reg;
        m_nxt         = m_reg;
        qm1_nxt       = qm1_reg;
        cnt_nxt       = cnt;
        is_mul_nxt    = is_mul;
        sign_diff_nxt = sign_diff;
        div_zero_nxt  = div_zero;
        alu_a         = 32'd0;
        alu_b         = 32'd0;
        alu_op        = op_add;
        shift_sign    = 1'b0;
        borrow        = 1'b0;
        r_sh          = {p_reg[30:0], q_reg[31]};

        case (state)
            MUL_IT: begin
                alu_a = p_reg;
                case ({q_reg[0], qm1_reg})
                    2'b01:   alu_b = m_reg;
                    2'b10: begin
                        alu_b  = m_reg;
                        alu_op = op_sub;
                    end
                    default: alu_b = 32'd0;
                endcase
                // true sign of the 33-bit sum, so P+M overflow still shifts correctly
                shift_sign = bus.alu_result[31] ^ bus.alu_overflow;
                p_nxt      = {shift_sign, bus.alu_result[31:1]};
                q_nxt      = {bus.alu_result[0], q_reg[31:1]};
                qm1_nxt    = q_reg[0];
                cnt_nxt    = cnt + 6'd1;
                if (cnt == 6'd31) state_nxt = DONE;
            end
            DIV_NA: begin
                alu_b  = q_reg;
                alu_op = op_sub;
                if (q_reg[31]) q_nxt = bus.alu_result;
                state_nxt = DIV_NB;
            end
            DIV_NB: begin
                alu_b  = m_reg;
                alu_op = op_sub;
                if (m_reg[31]) m_nxt = bus.alu_result;
                p_nxt     = 32'd0;
                cnt_nxt   = 6'd0;
                state_nxt = DIV_IT;
            end
            DIV_IT: begin
                alu_a  = r_sh;
                alu_b  = m_reg;
                alu_op = op_sub;
                // unsigned compare of R' against D using only the 32-bit difference
                borrow = (~r_sh[31] & m_reg[31]) |
                         (~(r_sh[31] ^ m_reg[31]) & bus.alu_result[31]);
                if (borrow) begin
                    p_nxt = r_sh;
                    q_nxt = {q_reg[30:0], 1'b0};
                end else begin
                    p_nxt = bus.alu_result;
                    q_nxt = {q_reg[30:0], 1'b1};
                end
                cnt_nxt = cnt + 6'd1;
                if (cnt == 6'd31) state_nxt = DIV_FIX;
            end
            DIV_FIX: begin
                alu_b  = q_reg;
                alu_op = op_sub;
                if (sign_diff) q_nxt = bus.alu_result;
                state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        if (bus.ctrl_MULT) begin
            p_nxt         = 32'd0;
            q_nxt         = bus.data_operandB;
            m_nxt         = bus.data_operandA;
            qm1_nxt       = 1'b0;
            cnt_nxt       = 6'd0;
            is_mul_nxt    = 1'b1;
            sign_diff_nxt = 1'b0;
            div_zero_nxt  = 1'b0;
            state_nxt     = MUL_IT;
            if (early_zero_en && (bus.data_operandA == 32'd0 || bus.data_operandB == 32'd0)) begin
                q_nxt     = 32'd0;
                state_nxt = DONE;
            end
        end else if (bus.ctrl_DIV) begin
            p_nxt         = 32'd0;
            q_nxt         = bus.data_operandA;
            m_nxt         = bus.data_operandB;
            qm1_nxt       = 1'b0;
            cnt_nxt       = 6'd0;
            is_mul_nxt    = 1'b0;
            sign_diff_nxt = bus.data_operandA[31] ^ bus.data_operandB[31];
            div_zero_nxt  = 1'b0;
            state_nxt     = DIV_NA;
            if (bus.data_operandB == 32'd0) begin
                q_nxt         = 32'd0;
                sign_diff_nxt = 1'b0;
                div_zero_nxt  = 1'b1;
                state_nxt     = DONE;
            end else if (early_zero_en && bus.data_operandA == 32'd0) begin
                q_nxt     = 32'd0;
                state_nxt = DONE;
            end
        end

        done_exc = is_mul_nxt ? (p_nxt != {32{q_nxt[31]}})
                              : (div_zero_nxt | (~sign_diff_nxt & q_nxt[31]));
    end

    // State and datapath registers; results latch on the edge that enters DONE
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            p_reg         <= 32'd0;
            q_reg         <= 32'd0;
            m_reg         <= 32'd0;
            qm1_reg       <= 1'b0;
            cnt           <= 6'd0;
            is_mul        <= 1'b0;
            sign_diff     <= 1'b0;
            div_zero      <= 1'b0;
            result_reg    <= 32'd0;
            exception_reg <= 1'b0;
        end else begin
            state     <= state_nxt;
            p_reg     <= p_nxt;
            q_reg     <= q_nxt;
            m_reg     <= m_nxt;
            qm1_reg   <= qm1_nxt;
            cnt       <= cnt_nxt;
            is_mul    <= is_mul_nxt;
            sign_diff <= sign_diff_nxt;
            div_zero  <= div_zero_nxt;
            if (state_nxt == DONE) begin
                result_reg    <= q_nxt;
                exception_reg <= done_exc;
            end
        end
    end

    assign bus.alu_opA        = alu_a;
    assign bus.alu_opB        = alu_b;
    assign bus.alu_opcode     = alu_op;
    assign bus.data_result    = result_reg;
    assign bus.data_exception = exception_reg;
    assign bus.data_resultRDY = (state == DONE);
    assign bus.busy           = (state != IDLE);

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// tb/tb_alu_muldiv_seq.sv - randomized self-checking bench for alu_muldiv_seq against an arithmetic reference model
module tb_alu_muldiv_seq;

`ifdef MULDIV_EARLY_ZERO_EN
    localparam bit early_zero_en = 1'b1;
`else
    localparam bit early_zero_en = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_res;
    logic        exp_exc;
    int          exp_lat;
    logic [31:0] alu_sum;
    logic [31:0] specials [5] = '{32'h0, 32'h1, 32'hffffffff, 32'h80000000, 32'h7fffffff};

    alu_muldiv_seq_if bus ();

    alu_muldiv_seq dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // the processor's ALU the sequencer borrows
    assign alu_sum = (bus.alu_opcode == 5'd1) ? bus.alu_opA - bus.alu_opB : bus.alu_opA + bus.alu_opB;
    assign bus.alu_result = alu_sum;
    assign bus.alu_overflow = (bus.alu_opcode == 5'd1)
        ? ((bus.alu_opA[31] != bus.alu_opB[31]) && (alu_sum[31] != bus.alu_opA[31]))
        : ((bus.alu_opA[31] == bus.alu_opB[31]) && (alu_sum[31] != bus.alu_opA[31]));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // reference: full-precision signed arithmetic, then range checks on the 32-bit result
    task automatic issue(input bit mul, input logic [31:0] a, input logic [31:0] b, input bit both);
        longint la, lb, pr;
        la = longint'($signed(a));
        lb = longint'($signed(b));
        if (mul) begin
            pr      = la * lb;
            exp_res = pr[31:0];
            exp_exc = (pr > 64'sd2147483647) || (pr < -64'sd2147483648);
            exp_lat = (early_zero_en && (a == 0 || b == 0)) ? 1 : 33;
        end else if (b == 0) begin
            exp_res = 32'd0;
            exp_exc = 1'b1;
            exp_lat = 1;
        end else begin
            pr      = la / lb;
            exp_res = pr[31:0];
            exp_exc = (pr > 64'sd2147483647);
            exp_lat = (early_zero_en && a == 0) ? 1 : 36;
        end
        bus.ctrl_MULT     = mul | both;
        bus.ctrl_DIV      = !mul | both;
        bus.data_operandA = a;
        bus.data_operandB = b;
    endtask

    task automatic finish_op(input string tag);
        int cyc;
        @(negedge clock);
        bus.ctrl_MULT     = 1'b0;
        bus.ctrl_DIV      = 1'b0;
        bus.data_operandA = $urandom;
        bus.data_operandB = $urandom;
        cyc = 1;
        while (!bus.data_resultRDY && cyc < 100) begin
            @(negedge clock);
            cyc++;
        end
        check({tag, "_lat"}, 32'(cyc), 32'(exp_lat));
        check({tag, "_res"}, bus.data_result, exp_res);
        check({tag, "_exc"}, 32'(bus.data_exception), 32'(exp_exc));
    endtask

    task automatic after_done(input string tag);
        @(negedge clock);
        check({tag, "_rdy_off"}, 32'(bus.data_resultRDY), 32'd0);
        check({tag, "_busy_off"}, 32'(bus.busy), 32'd0);
        check({tag, "_hold"}, bus.data_result, exp_res);
    endtask

    task automatic run_op(input bit mul, input logic [31:0] a, input logic [31:0] b,
                          input bit both, input string tag);
        @(negedge clock);
        issue(mul, a, b, both);
        finish_op(tag);
        after_done(tag);
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_rdy"}, 32'(bus.data_resultRDY), 32'd0);
        check({tag, "_busy"}, 32'(bus.busy), 32'd0);
        check({tag, "_res"}, bus.data_result, 32'd0);
        check({tag, "_exc"}, 32'(bus.data_exception), 32'd0);
        check({tag, "_opa"}, bus.alu_opA, 32'd0);
        check({tag, "_opb"}, bus.alu_opB, 32'd0);
        check({tag, "_opc"}, 32'(bus.alu_opcode), 32'd0);
    endtask

    initial begin
        bus.ctrl_MULT     = 1'b0;
        bus.ctrl_DIV      = 1'b0;
        bus.data_operandA = 32'd0;
        bus.data_operandB = 32'd0;
        reset = 1'b1;
        repeat (3) @(negedge clock);
        check_idle_zero("reset");
        reset = 1'b0;

        run_op(1'b1, 32'd0, 32'd9, 1'b0, "mul_zero");
        run_op(1'b0, 32'd0, -32'sd4, 1'b0, "div_zero_dividend");
        run_op(1'b0, 32'd5, 32'd0, 1'b0, "div_by_zero");
        run_op(1'b1, 32'd7, -32'sd3, 1'b0, "mul_7x-3");
        run_op(1'b1, 32'h00010000, 32'h00010000, 1'b0, "mul_ovf");
        run_op(1'b1, 32'h80000000, 32'd1, 1'b0, "mul_min");
        run_op(1'b0, -32'sd100, 32'd7, 1'b0, "div_neg");
        run_op(1'b0, 32'h80000000, 32'hffffffff, 1'b0, "div_ovf");

        // reset in cycle 10 of a multiply
        @(negedge clock);
        issue(1'b1, 32'd123, 32'd456, 1'b0);
        @(negedge clock);
        bus.ctrl_MULT = 1'b0;
        repeat (9) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check_idle_zero("mid_reset");
        reset = 1'b0;
        run_op(1'b1, 32'h00001234, 32'h0000fff0, 1'b1, "both_high");

        // a divide restarts a multiply in flight; no pulse for the aborted multiply
        @(negedge clock);
        issue(1'b1, 32'd3, 32'd4, 1'b0);
        @(negedge clock);
        bus.ctrl_MULT = 1'b0;
        repeat (4) begin
            @(negedge clock);
            check("abort_no_rdy", 32'(bus.data_resultRDY), 32'd0);
        end
        issue(1'b0, -32'sd1000, 32'd3, 1'b0);
        finish_op("abort_div");
        after_done("abort_div");

        // starts issued in the DONE cycle
        @(negedge clock);
        issue(1'b1, -32'sd5, 32'd6, 1'b0);
        finish_op("b2b_first");
        issue(1'b0, 32'd1000, -32'sd3, 1'b0);
        finish_op("b2b_second");
        issue(1'b0, 32'd7, 32'd0, 1'b0);
        finish_op("b2b_divzero");
        after_done("b2b_divzero");

        for (int i = 0; i < 40; i++) begin
            logic [31:0] a, b;
            int s;
            case ($urandom_range(0, 3))
                0: begin a = $urandom; b = $urandom; end
                1: begin
                    s = $urandom_range(0, 40); a = 32'(s - 20);
                    s = $urandom_range(0, 40); b = 32'(s - 20);
                end
                2: begin
                    a = specials[$urandom_range(0, 4)];
                    b = specials[$urandom_range(0, 4)];
                end
                default: begin
                    a = $urandom;
                    s = $urandom_range(0, 40); b = 32'(s - 20);
                end
            endcase
            run_op(1'($urandom_range(0, 1)), a, b, 1'b0, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
